// File: rtl/onehot_decoder_seq.sv
// Sequential 2-to-4 decoder: accepts a 2-bit code through a valid/ready handshake.
// It holds the matching one-hot line for HOLD_CYCLES, then idles low for GAP_CYCLES.
module onehot_decoder_seq #(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned GAP_CYCLES  = 1,
  parameter int unsigned CNT_W       = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [1:0]         in_code,
  output logic               in_ready,
  output logic [3:0]         out_onehot,
  output logic               out_valid,
  output logic               busy,
  input  logic               clr_cnt,
  output logic [4*CNT_W-1:0] event_cnt
);

  localparam int unsigned MAX_T = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int unsigned TMR_W = (MAX_T > 1) ? $clog2(MAX_T) : 1;
  localparam logic [TMR_W-1:0] HOLD_LOAD = TMR_W'(HOLD_CYCLES - 1);
  localparam logic [TMR_W-1:0] GAP_LOAD  = TMR_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [TMR_W-1:0]   r_tmr;
  logic [TMR_W-1:0]   w_tmr_nxt;
  logic [1:0]         r_code;
  logic [CNT_W-1:0]   r_cnt [4];
  logic               w_accept;
  logic               w_tmr_done;

  assign w_accept   = in_valid && (r_state == S_IDLE);
  assign w_tmr_done = (r_tmr == '0);

  // Status outputs are pure decodes of the state register, so reset clears them at once.
  assign in_ready   = (r_state == S_IDLE);
  assign out_valid  = (r_state == S_HOLD);
  assign busy       = (r_state != S_IDLE);
  assign out_onehot = (r_state == S_HOLD) ? (4'b0001 << r_code) : 4'b0000;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_tmr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_tmr   <= w_tmr_nxt;
    end
  end

  // The timer counts down from length-1, so each phase lasts exactly its programmed length.
  always_comb begin
    w_state_nxt = r_state;
    w_tmr_nxt   = r_tmr;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_HOLD;
          w_tmr_nxt   = HOLD_LOAD;
        end
      end
      S_HOLD: begin
        if (w_tmr_done) begin
          if (GAP_CYCLES > 0) begin
            w_state_nxt = S_GAP;
            w_tmr_nxt   = GAP_LOAD;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_tmr_nxt = r_tmr - TMR_W'(1);
        end
      end
      S_GAP: begin
        if (w_tmr_done) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_tmr_nxt = r_tmr - TMR_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_tmr_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_code <= 2'd0;
    end else if (w_accept) begin
      r_code <= in_code;
    end
  end

  // Saturating per-code accept counters; a clear on the accept edge takes priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
    end else if (clr_cnt) begin
      for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
    end else if (w_accept && (r_cnt[in_code] != CNT_MAX)) begin
      r_cnt[in_code] <= r_cnt[in_code] + CNT_W'(1);
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_evt
    assign event_cnt[g*CNT_W +: CNT_W] = r_cnt[g];
  end

endmodule

// File: tb/tb_onehot_decoder_seq.sv
// Bench for onehot_decoder_seq: two instances (4/1 and 1/0 hold/gap) checked every cycle
// against a timestamp-based model of accepts, hold/gap windows and saturating counts.
module tb_onehot_decoder_seq;

  localparam int unsigned CW = 8;
  localparam int unsigned H0 = 4;
  localparam int unsigned G0 = 1;
  localparam int unsigned H1 = 1;
  localparam int unsigned G1 = 0;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic            vld [2];
  logic            clr [2];
  logic [1:0]      code [2];
  logic            rdy [2];
  logic            ov [2];
  logic            bsy [2];
  logic [3:0]      oh [2];
  logic [4*CW-1:0] ev [2];

  int n;
  int m_last [2];
  int m_code [2];
  int m_cnt [2][4];
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  onehot_decoder_seq #(.HOLD_CYCLES(H0), .GAP_CYCLES(G0), .CNT_W(CW)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(vld[0]), .in_code(code[0]), .in_ready(rdy[0]),
    .out_onehot(oh[0]), .out_valid(ov[0]), .busy(bsy[0]), .clr_cnt(clr[0]), .event_cnt(ev[0])
  );

  onehot_decoder_seq #(.HOLD_CYCLES(H1), .GAP_CYCLES(G1), .CNT_W(CW)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(vld[1]), .in_code(code[1]), .in_ready(rdy[1]),
    .out_onehot(oh[1]), .out_valid(ov[1]), .busy(bsy[1]), .clr_cnt(clr[1]), .event_cnt(ev[1])
  );

  function automatic int hc(input int i);
    return (i == 0) ? int'(H0) : int'(H1);
  endfunction

  function automatic int gc(input int i);
    return (i == 0) ? int'(G0) : int'(G1);
  endfunction

  // Model: the block is ready once the whole hold+gap window after the last accept has passed.
  function automatic logic mready(input int i);
    return n >= m_last[i] + hc(i) + gc(i);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d, t=%0t)", tag, got, exp, n, $time);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      logic            hold;
      logic            busy_e;
      logic [4*CW-1:0] exp_ev;
      hold   = (n >= m_last[i]) && (n < m_last[i] + hc(i));
      busy_e = (n < m_last[i] + hc(i) + gc(i));
      for (int k = 0; k < 4; k++) exp_ev[k*CW +: CW] = CW'(m_cnt[i][k]);
      check($sformatf("onehot%0d", i), 32'(oh[i]), hold ? (32'd1 << m_code[i]) : 32'd0);
      check($sformatf("out_valid%0d", i), 32'(ov[i]), 32'(hold));
      check($sformatf("busy%0d", i), 32'(bsy[i]), 32'(busy_e));
      check($sformatf("in_ready%0d", i), 32'(rdy[i]), 32'(!busy_e));
      check($sformatf("event_cnt%0d", i), 32'(ev[i]), 32'(exp_ev));
    end
  endtask

  // One clock: decide accepts from pre-edge inputs, advance the model, check after the edge.
  task automatic tick();
    logic acc [2];
    for (int i = 0; i < 2; i++) acc[i] = vld[i] && mready(i);
    @(posedge clk);
    n++;
    for (int i = 0; i < 2; i++) begin
      if (acc[i]) begin
        m_last[i] = n;
        m_code[i] = int'(code[i]);
      end
      if (clr[i]) begin
        for (int k = 0; k < 4; k++) m_cnt[i][k] = 0;
      end else if (acc[i] && m_cnt[i][code[i]] < CMAX) begin
        m_cnt[i][code[i]]++;
      end
    end
    #1;
    check_all();
    @(negedge clk);
  endtask

  // Asserts reset mid-cycle and checks that outputs clear before any clock edge.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rst_onehot%0d", i), 32'(oh[i]), 32'd0);
      check($sformatf("rst_valid%0d", i), 32'(ov[i]), 32'd0);
      check($sformatf("rst_busy%0d", i), 32'(bsy[i]), 32'd0);
      check($sformatf("rst_evt%0d", i), 32'(ev[i]), 32'd0);
    end
    n = 0;
    for (int i = 0; i < 2; i++) begin
      m_last[i] = -1000;
      m_code[i] = 0;
      for (int k = 0; k < 4; k++) m_cnt[i][k] = 0;
      vld[i] = 1'b0;
      clr[i] = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_ready(input int i);
    for (int c = 0; c < 20 && !mready(i); c++) tick();
  endtask

  initial begin
    int seq [3];
    int idx;
    seq[0] = 0; seq[1] = 1; seq[2] = 3;
    for (int i = 0; i < 2; i++) begin
      vld[i] = 1'b0; clr[i] = 1'b0; code[i] = 2'd0;
    end
    @(negedge clk);
    do_reset();
    repeat (3) tick();
    check("idle_ready", 32'(rdy[0]), 32'd1);

    // Single accept of code 2
    vld[0] = 1'b1; code[0] = 2'd2;
    tick();
    vld[0] = 1'b0; code[0] = 2'($urandom);
    check("code2_onehot", 32'(oh[0]), 32'h4);
    repeat (6) tick();
    check("code2_cnt", 32'(ev[0][23:16]), 32'd1);

    // Back-to-back requests 0,1,3 with in_code scrambled while busy
    do_reset();
    idx = 0;
    for (int c = 0; c < 22; c++) begin
      if (mready(0)) begin
        if (idx < 3) begin
          vld[0] = 1'b1; code[0] = 2'(seq[idx]); idx++;
        end else begin
          vld[0] = 1'b0;
        end
      end else begin
        code[0] = 2'($urandom);
      end
      tick();
    end
    check("seq_counts", 32'(ev[0]), {8'd1, 8'd0, 8'd1, 8'd1});

    // Saturation on the no-gap instance while instance 0 takes random traffic
    vld[1] = 1'b1; code[1] = 2'd3;
    for (int c = 0; c < 530; c++) begin
      vld[0]  = 1'($urandom);
      code[0] = 2'($urandom);
      clr[0]  = ($urandom_range(0, 31) == 0);
      tick();
    end
    vld[1] = 1'b0; vld[0] = 1'b0; clr[0] = 1'b0;
    check("sat_cnt3", 32'(ev[1][31:24]), 32'd255);
    tick();

    // Reset during the second hold cycle of code 1
    wait_ready(0);
    vld[0] = 1'b1; code[0] = 2'd1;
    tick();
    vld[0] = 1'b0;
    tick();
    check("midhold_onehot", 32'(oh[0]), 32'h2);
    do_reset();
    tick();
    check("post_rst_ready", 32'(rdy[0]), 32'd1);
    vld[0] = 1'b1; code[0] = 2'd2;
    tick();
    vld[0] = 1'b0;
    check("post_rst_onehot", 32'(oh[0]), 32'h4);
    repeat (6) tick();

    // Five accepts of code 0, then a clear coincident with a sixth accept
    do_reset();
    for (int c = 0; c < 40 && m_cnt[0][0] < 5; c++) begin
      vld[0] = mready(0); code[0] = 2'd0;
      tick();
    end
    vld[0] = 1'b0;
    check("pre_clr_cnt0", 32'(ev[0][7:0]), 32'd5);
    wait_ready(0);
    vld[0] = 1'b1; clr[0] = 1'b1; code[0] = 2'd0;
    tick();
    vld[0] = 1'b0; clr[0] = 1'b0;
    check("clr_cnt0", 32'(ev[0][7:0]), 32'd0);
    check("clr_onehot", 32'(oh[0]), 32'h1);
    repeat (8) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
